seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Parametrised multiplexed 7-segment display driver: next generation of the 4-digit scanner.
//   Converts a binary value to BCD with a sequential double-dabble engine (load/busy handshake).
//   Scans NUM_DIGITS common-select lines with a programmable dwell, leading-zero blanking,
//   per-digit decimal points, overflow indication and a lamp-test mode.
//   Sits between the value-producing logic and the board display pins, clocked by clk_16k.
// PARAMETERS
//   NUM_DIGITS  4   number of display digits (1..8); DIG width
//   IN_WIDTH    14  binary input width (1..27)
//   SCAN_DIV    1   clk_16k cycles each digit stays selected (>=1)
//   BLANK_LZ    1   1 = blank leading zeros; 0 = show all digits
// PORTS
//   clk_16k   in   1                 scan/system clock, all logic on rising edge
//   rst       in   1                 synchronous reset, active-high
//   A         in   IN_WIDTH          unsigned binary value, sampled on an accepted load
//   load      in   1                 request conversion of A; accepted only when busy=0
//   busy      out  1                 conversion in progress; load ignored while high
//   dp        in   NUM_DIGITS        decimal-point enables, bit i = digit i (0 = least significant)
//   test      in   1                 lamp test: all segments and DP lit
//   OL        out  7                 segments a..g = OL[6]..OL[0], active-high, registered
//   DP        out  1                 decimal point of selected digit, active-high, registered
//   DIG       out  NUM_DIGITS        one-hot digit select, DIG[NUM_DIGITS-1] = most significant
//   overflow  out  1                 last converted value >= 10**NUM_DIGITS
// BEHAVIOUR
//   Reset: OL=0, DP=0, DIG=0, busy=0, overflow=0, display BCD=0, scan index=NUM_DIGITS-1,
//     prescaler=0; FSM to IDLE. Reset mid-conversion aborts it, and the display holds 0.
//   FSM IDLE->SHIFT on load&~busy (A captured on that edge, overflow precomputed vs 10**NUM_DIGITS).
//   SHIFT: one double-dabble step per cycle (add-3 to every BCD nibble >=5, then shift left 1).
//     busy=1 for exactly IN_WIDTH cycles after the accept edge. On the edge ending the last step:
//     display BCD register and overflow update together, busy->0, FSM->IDLE.
//   load during busy (including the final SHIFT cycle) is dropped, never queued.
//   Internal BCD width 4*NUM_DIGITS; when overflow=1 the BCD content is not displayed.
//   Scan: prescaler counts 0..SCAN_DIV-1; on terminal count, index decrements and wraps 0->NUM_DIGITS-1.
//     First edge after reset release: DIG=onehot(NUM_DIGITS-1) with matching OL/DP.
//     OL, DP and DIG are updated on the same edge; no segment/select skew is allowed.
//   Digit decode: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111
//     7=1110000 8=1111111 9=1111011, any other value=0000000.
//   Blanking (BLANK_LZ=1): digits above the most significant non-zero digit give OL=0;
//     digit 0 is never blanked, so value 0 shows "0". DP is never blanked.
//   Overflow: every digit shows '-' (OL=0000001); DP still follows dp.
//   Priority per selected digit: test (OL=1111111, DP=1) > overflow > blank > decode.
//   Scanning never stalls for conversion, load or test; a display change takes effect on the next
//     scanned digit.
// TESTING
//   1 rst, A=1234, load 1 cycle, SCAN_DIV=1 -> busy high 14 cycles; then DIG 1000,0100,0010,0001
//     with OL 0110000,1101101,1111001,0110011, repeating.
//   2 A=7 -> digits 3..1 give OL=0000000; digit 0 gives 1110000; with BLANK_LZ=0, digits 3..1 give 1111110.
//   3 A=10000 -> overflow=1, all digits 0000001; then A=0 -> overflow=0, only digit 0 lit 1111110.
//   4 load 1234, then load 5678 two cycles later -> second load ignored, display 1234.
//   5 SCAN_DIV=3, dp=0100 -> each DIG held 3 cycles; DP=1 only while DIG=0100.
//   6 test=1 -> OL=1111111, DP=1 on every digit; rst mid-conversion -> busy=0 next cycle, display 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment display driver with a sequential double-dabble
// binary-to-BCD engine, leading-zero blanking, decimal points, overflow dash and lamp test.
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int IN_WIDTH   = 14,
   parameter int SCAN_DIV   = 1,
   parameter int BLANK_LZ   = 1
) (
   input  logic                  clk_16k,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   A,
   input  logic                  load,
   output logic                  busy,
   input  logic [NUM_DIGITS-1:0] dp,
   input  logic                  test,
   output logic [6:0]            OL,
   output logic                  DP,
   output logic [NUM_DIGITS-1:0] DIG,
   output logic                  overflow
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(IN_WIDTH + 1);

   localparam logic [31:0]      OVF_LIMIT = 32'(10 ** NUM_DIGITS);
   localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PS_W-1:0]  PS_TOP    = PS_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IN_WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
         end else begin
            adj[4*k +: 4] = bcd[4*k +: 4];
         end
      end
      return adj;
   endfunction

   state_t                  state_r;
   state_t                  state_nx_s;
   logic                    accept_s;
   logic                    step_s;
   logic                    last_step_s;
   logic [IN_WIDTH-1:0]     bin_r;
   logic [IN_WIDTH-1:0]     bin_step_s;
   logic [BCD_W-1:0]        bcd_r;
   logic [BCD_W-1:0]        bcd_adj_s;
   logic [BCD_W-1:0]        bcd_step_s;
   logic                    bcd_carry_s;
   logic [BCD_W-1:0]        disp_bcd_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    ovf_pend_r;
   logic                    overflow_r;
   logic [31:0]             a_ext_s;
   logic [PS_W-1:0]         ps_r;
   logic [IDX_W-1:0]        idx_r;
   logic [NUM_DIGITS-1:0]   lz_s;
   logic                    lz_run_s;
   logic [3:0]              nibble_s;
   logic                    blank_s;
   logic [6:0]              ol_s;
   logic                    dp_s;
   logic [NUM_DIGITS-1:0]   dig_s;
   logic [6:0]              ol_r;
   logic                    dp_r;
   logic [NUM_DIGITS-1:0]   dig_r;

   // Conversion FSM state register
   always_ff @(posedge clk_16k) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Conversion FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE:  state_nx_s = load ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_nx_s = (cnt_r == CNT_LAST) ? ST_IDLE : ST_SHIFT;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // Conversion FSM decoded controls
   always_comb begin
      accept_s    = 1'b0;
      step_s      = 1'b0;
      last_step_s = 1'b0;
      case (state_r)
         ST_IDLE:  accept_s = load;
         ST_SHIFT: begin
            step_s      = 1'b1;
            last_step_s = (cnt_r == CNT_LAST);
         end
         default:  accept_s = 1'b0;
      endcase
   end

   assign busy = (state_r == ST_SHIFT);

   assign a_ext_s    = 32'(A);
   assign bcd_adj_s  = dabble_adjust(bcd_r);
   assign {bcd_carry_s, bcd_step_s} = {bcd_adj_s, bin_r[IN_WIDTH-1]};
   assign bin_step_s = bin_r << 1'b1;

   // Double-dabble datapath and display registers
   always_ff @(posedge clk_16k) begin
      if (rst) begin
         bin_r      <= '0;
         bcd_r      <= '0;
         cnt_r      <= '0;
         ovf_pend_r <= 1'b0;
         disp_bcd_r <= '0;
         overflow_r <= 1'b0;
      end else if (accept_s) begin
         bin_r      <= A;
         bcd_r      <= '0;
         cnt_r      <= '0;
         ovf_pend_r <= (a_ext_s >= OVF_LIMIT);
      end else if (step_s) begin
         // a carry out of the top nibble can only happen for out-of-range values
         bin_r      <= bin_step_s;
         bcd_r      <= bcd_step_s;
         cnt_r      <= cnt_r + 1'b1;
         ovf_pend_r <= ovf_pend_r | bcd_carry_s;
         if (last_step_s) begin
            disp_bcd_r <= bcd_step_s;
            overflow_r <= ovf_pend_r | bcd_carry_s;
         end
      end
   end

   // Scan prescaler and digit index
   always_ff @(posedge clk_16k) begin
      if (rst) begin
         ps_r  <= '0;
         idx_r <= IDX_TOP;
      end else if (ps_r == PS_TOP) begin
         ps_r  <= '0;
         idx_r <= (idx_r == '0) ? IDX_TOP : (idx_r - 1'b1);
      end else begin
         ps_r  <= ps_r + 1'b1;
      end
   end

   // Leading-zero map: bit i set when digit i and every digit above it are zero
   always_comb begin
      lz_s     = '0;
      lz_run_s = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run_s = lz_run_s & (disp_bcd_r[4*i +: 4] == 4'd0);
         lz_s[i]  = lz_run_s;
      end
   end

   assign nibble_s = disp_bcd_r[{idx_r, 2'b00} +: 4];
   assign blank_s  = (BLANK_LZ != 0) && (idx_r != '0) && lz_s[idx_r];

   // Segment and decimal-point selection with test > overflow > blank > decode priority
   always_comb begin
      ol_s = 7'b0000000;
      dp_s = dp[idx_r];
      if (test) begin
         ol_s = 7'b1111111;
         dp_s = 1'b1;
      end else if (overflow_r) begin
         ol_s = 7'b0000001;
      end else if (blank_s) begin
         ol_s = 7'b0000000;
      end else begin
         ol_s = seg_decode(nibble_s);
      end
   end

   // One-hot select for the current index
   always_comb begin
      dig_s        = '0;
      dig_s[idx_r] = 1'b1;
   end

   // Segment, point and select registered together so they change on the same edge
   always_ff @(posedge clk_16k) begin
      if (rst) begin
         ol_r  <= 7'b0000000;
         dp_r  <= 1'b0;
         dig_r <= '0;
      end else begin
         ol_r  <= ol_s;
         dp_r  <= dp_s;
         dig_r <= dig_s;
      end
   end

   assign OL       = ol_r;
   assign DP       = dp_r;
   assign DIG      = dig_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (default, no blanking, slow scan) checked every
// cycle against an arithmetic display model, plus directed literal checks.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int IW = 14;

   logic          clk_16k = 1'b0;
   logic          rst;
   logic          load;
   logic          test;
   logic [IW-1:0] A;
   logic [ND-1:0] dp;

   logic [6:0]    ol0, ol1, ol2;
   logic          dp0, dp1, dp2;
   logic [ND-1:0] dig0, dig1, dig2;
   logic          busy0, busy1, busy2;
   logic          ovf0, ovf1, ovf2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_16k = ~clk_16k;

   seg7_scan_driver #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .SCAN_DIV(1), .BLANK_LZ(1)) dut (
      .clk_16k(clk_16k), .rst(rst), .A(A), .load(load), .busy(busy0), .dp(dp), .test(test),
      .OL(ol0), .DP(dp0), .DIG(dig0), .overflow(ovf0));

   seg7_scan_driver #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .SCAN_DIV(1), .BLANK_LZ(0)) dut_nb (
      .clk_16k(clk_16k), .rst(rst), .A(A), .load(load), .busy(busy1), .dp(dp), .test(test),
      .OL(ol1), .DP(dp1), .DIG(dig1), .overflow(ovf1));

   seg7_scan_driver #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .SCAN_DIV(3), .BLANK_LZ(1)) dut_sd (
      .clk_16k(clk_16k), .rst(rst), .A(A), .load(load), .busy(busy2), .dp(dp), .test(test),
      .OL(ol2), .DP(dp2), .DIG(dig2), .overflow(ovf2));

   // Model state
   int          sd_t  [3] = '{1, 1, 3};
   bit          blz_t [3] = '{1'b1, 1'b0, 1'b1};
   logic [6:0]  seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   logic [6:0]    e_ol  [3];
   logic          e_dp  [3];
   logic [ND-1:0] e_dig [3];
   logic          e_busy;
   logic          e_ovf;
   bit            model_valid = 1'b0;
   int            m_k, m_left, m_pend, m_val;
   bit            m_ovf;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int p10(input int d);
      int r = 1;
      for (int j = 0; j < d; j++) r = r * 10;
      return r;
   endfunction

   function automatic int cur_digit(input int k, input int sd);
      return (ND - 1) - ((k / sd) % ND);
   endfunction

   function automatic logic [6:0] exp_seg(input int k, input int sd, input bit blz,
                                          input int val, input bit ovf, input bit tst);
      int d = cur_digit(k, sd);
      if (tst) return 7'b1111111;
      if (ovf) return 7'b0000001;
      if (blz && d > 0 && val < p10(d)) return 7'b0000000;
      return seg_tab[(val / p10(d)) % 10];
   endfunction

   // Model: computes what each edge must produce from the pre-edge display state
   initial begin
      m_k = 0; m_left = 0; m_pend = 0; m_val = 0; m_ovf = 1'b0;
      forever begin
         @(posedge clk_16k);
         if (rst) begin
            for (int i = 0; i < 3; i++) begin
               e_ol[i] = 7'b0; e_dp[i] = 1'b0; e_dig[i] = '0;
            end
            m_k = 0; m_left = 0; m_val = 0; m_ovf = 1'b0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               e_ol[i]  = exp_seg(m_k, sd_t[i], blz_t[i], m_val, m_ovf, test);
               e_dp[i]  = test ? 1'b1 : dp[cur_digit(m_k, sd_t[i])];
               e_dig[i] = ND'(1) << cur_digit(m_k, sd_t[i]);
            end
            m_k++;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_val = m_pend;
                  m_ovf = (m_pend >= p10(ND));
               end
            end else if (load) begin
               m_pend = int'(A);
               m_left = IW;
            end
         end
         e_busy = (m_left > 0);
         e_ovf  = m_ovf;
         model_valid = 1'b1;
      end
   end

   task automatic cmp_inst(input int i, input logic [6:0] ol, input logic dpv,
                           input logic [ND-1:0] dig, input logic bsy, input logic ov);
      check($sformatf("OL[%0d]", i), ol, e_ol[i]);
      check($sformatf("DP[%0d]", i), dpv, e_dp[i]);
      check($sformatf("DIG[%0d]", i), dig, e_dig[i]);
      check($sformatf("busy[%0d]", i), bsy, e_busy);
      check($sformatf("overflow[%0d]", i), ov, e_ovf);
   endtask

   // Every-cycle comparison on the falling edge
   initial begin
      forever begin
         @(negedge clk_16k);
         if (model_valid) begin
            cmp_inst(0, ol0, dp0, dig0, busy0, ovf0);
            cmp_inst(1, ol1, dp1, dig1, busy1, ovf1);
            cmp_inst(2, ol2, dp2, dig2, busy2, ovf2);
         end
      end
   end

   task automatic wait_dig0(input logic [ND-1:0] want);
      int n = 0;
      while (dig0 !== want && n < 40) begin
         @(negedge clk_16k);
         n++;
      end
      check("wait_dig", dig0, want);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy0 !== 1'b0 && n < 100) begin
         @(negedge clk_16k);
         n++;
      end
      check("wait_idle", busy0, 1'b0);
   endtask

   task automatic do_load(input int a);
      @(negedge clk_16k);
      A = IW'(a); load = 1'b1;
      @(negedge clk_16k);
      load = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk_16k);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; load = 1'b0; test = 1'b0; dp = '0; A = '0;
      repeat (3) @(negedge clk_16k);
      check("reset OL", ol0, 7'b0);
      check("reset DIG", dig0, 4'b0000);
      check("reset busy", busy0, 1'b0);
      check("reset overflow", ovf0, 1'b0);
      rst = 1'b0;
      @(negedge clk_16k);
      check("first DIG", dig0, 4'b1000);
      check("first DIG slow", dig2, 4'b1000);
      check("first OL blank", ol0, 7'b0000000);

      // 1234 conversion and busy length
      A = 14'd1234; load = 1'b1;
      @(negedge clk_16k);
      load = 1'b0;
      n = 0;
      while (busy0 && n < 100) begin
         n++;
         @(negedge clk_16k);
      end
      check("busy cycles", n, 14);
      repeat (2) @(negedge clk_16k);
      wait_dig0(4'b1000); check("1234 d3", ol0, 7'b0110000);
      @(negedge clk_16k); check("1234 sel2", dig0, 4'b0100); check("1234 d2", ol0, 7'b1101101);
      @(negedge clk_16k); check("1234 sel1", dig0, 4'b0010); check("1234 d1", ol0, 7'b1111001);
      @(negedge clk_16k); check("1234 sel0", dig0, 4'b0001); check("1234 d0", ol0, 7'b0110011);

      // blanking vs no blanking
      do_load(7);
      wait_dig0(4'b0001); check("7 d0", ol0, 7'b1110000);
      wait_dig0(4'b1000); check("7 d3 blank", ol0, 7'b0000000);
      check("7 nb sel", dig1, 4'b1000); check("7 nb d3", ol1, 7'b1111110);

      // overflow then zero
      do_load(10000);
      check("ovf flag", ovf0, 1'b1);
      wait_dig0(4'b0010); check("ovf dash", ol0, 7'b0000001);
      do_load(0);
      check("ovf clear", ovf0, 1'b0);
      wait_dig0(4'b0001); check("zero d0", ol0, 7'b1111110);
      wait_dig0(4'b0100); check("zero d2", ol0, 7'b0000000);

      // load during busy is dropped
      @(negedge clk_16k); A = 14'd1234; load = 1'b1;
      @(negedge clk_16k); load = 1'b0;
      @(negedge clk_16k); A = 14'd5678; load = 1'b1;
      @(negedge clk_16k); load = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk_16k);
      wait_dig0(4'b0001); check("drop d0", ol0, 7'b0110011);
      wait_dig0(4'b0010); check("drop d1", ol0, 7'b1111001);

      // slow scan dwell and decimal point
      dp = 4'b0100;
      n = 0;
      while (dig2 === 4'b0100 && n < 40) begin @(negedge clk_16k); n++; end
      n = 0;
      while (dig2 !== 4'b0100 && n < 40) begin @(negedge clk_16k); n++; end
      n = 0;
      while (dig2 === 4'b0100 && n < 10) begin
         check("slow DP on", dp2, 1'b1);
         n++;
         @(negedge clk_16k);
      end
      check("slow dwell", n, 3);
      check("slow DP off", dp2, 1'b0);

      // lamp test
      test = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_16k);
         check("test OL", ol0, 7'b1111111);
         check("test DP", dp0, 1'b1);
      end
      test = 1'b0;

      // reset mid-conversion
      @(negedge clk_16k); A = 14'd9999; load = 1'b1;
      @(negedge clk_16k); load = 1'b0;
      repeat (5) @(negedge clk_16k);
      check("mid busy", busy0, 1'b1);
      rst = 1'b1;
      @(negedge clk_16k);
      check("abort busy", busy0, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk_16k);
      check("after abort busy", busy0, 1'b0);
      wait_dig0(4'b0001); check("abort d0", ol0, 7'b1111110);
      wait_dig0(4'b1000); check("abort d3", ol0, 7'b0000000);

      repeat (4) @(negedge clk_16k);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
